conv_sum_scheduler: RTL and testbench
=====================================

CONV_SUM_SCHEDULER -- requirements
Module: conv_sum_scheduler

Interface
REQ-001 SHALL have parameters: BITSIZE, 14, product width; NUM_INPUTS, 27, operands per window; BIAS_SIZE, 14, bias width; FIFO_DEPTH, 8, result FIFO entries (power of 2); CNT_W, 16, window counter width.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 cfg_start  in  1  job start pulse; cfg_num_windows  in  CNT_W  windows per channel; cfg_num_channels  in  8  output channels.
REQ-005 busy  out  1  job active; done  out  1  one-cycle job-complete pulse; err  out  1  sticky result-drop flag.
REQ-006 in_valid  in  1; in_ready  out  1; in_data  in  NUM_INPUTS*BITSIZE  window products.
REQ-007 bias_addr  out  8  current channel index; bias_data  in  BIAS_SIZE  bias, combinational lookup same cycle.
REQ-008 adder_start  out  1; adder_data  out  NUM_INPUTS*BITSIZE; adder_bias  out  BIAS_SIZE  drive the adder tree.
REQ-009 adder_valid  in  1; adder_sum  in  BITSIZE+5  adder tree result, fixed 5-cycle latency, no stall.
REQ-010 out_valid  out  1; out_ready  in  1; out_data  out  BITSIZE+5; out_last  out  1  final result of job.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN.
REQ-012 IDLE: cfg_start=1 latches cfg_num_windows/cfg_num_channels, clears err, zeroes all counters; goes to RUN, or to DONE if either config value is 0.
REQ-013 cfg_start SHALL be ignored outside IDLE.
REQ-014 Accept = in_valid & in_ready; in_ready=1 only in RUN when (fifo_count + inflight) < FIFO_DEPTH.
REQ-015 adder_start SHALL equal accept combinationally; adder_data=in_data; adder_bias=bias_data; all three zero when no accept.
REQ-016 bias_addr SHALL equal the channel counter; window counter increments per accept, wraps to 0 at cfg_num_windows-1 and increments channel counter.
REQ-017 Accept of the last window of the last channel SHALL move RUN->DRAIN; in_ready=0 from the next cycle.
REQ-018 inflight SHALL +1 on accept, -1 on adder_valid, unchanged on both in the same cycle; never exceeds FIFO_DEPTH.
REQ-019 adder_valid SHALL push adder_sum into the FIFO; pushed data visible on out_data the cycle after push (out_valid=1 when FIFO non-empty).
REQ-020 Pop on out_valid & out_ready; simultaneous push and pop SHALL keep fifo_count unchanged and preserve order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-021 out_last=1 with the head entry when it is the cfg_num_windows*cfg_num_channels-th result of the job (retire counter).
REQ-022 DRAIN->DONE when inflight=0, FIFO empty, and last result popped; DONE asserts done=1 for one cycle, then IDLE.
REQ-023 adder_valid with FIFO full or in IDLE SHALL drop the sum and set err=1 until next accepted cfg_start.
REQ-024 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, clear counters, inflight, FIFO pointers, err; all outputs 0 (in_ready, busy, done, adder_*, out_*, bias_addr).
REQ-026 Reset mid-job SHALL abandon the job; adder results arriving after release in IDLE set err.

Verification
REQ-027 windows=3, channels=2, bias[0]=5, bias[1]=-7, in_valid held, out_ready=1 -> 6 adder_start pulses, bias_addr 0,0,0,1,1,1, 6 results in order, out_last on 6th, done 1 cycle later after pop.
REQ-028 windows=20, channels=1, out_ready=0 -> exactly 8 accepts, in_ready low; raise out_ready -> remaining 12 accepted, 20 results, no err.
REQ-029 windows=0 or channels=0 + cfg_start -> done pulse 2 cycles later, no adder_start, no out_valid.
REQ-030 cfg_start pulsed during RUN -> ignored, counts unchanged; push and pop same cycle with fifo_count=4 -> stays 4, order preserved.
REQ-031 rst low mid-RUN with 3 inflight -> all outputs 0 at once; 3 stray adder_valid after release -> err=1, FIFO empty.
REQ-032 out_ready toggling 1010 random, windows=9, channels=3 -> 27 results matching scoreboard sums (products + channel bias), out_data stable while stalled.

Source files
------------

// File: rtl/conv_sum_scheduler_if.sv
// Stream, bias-lookup and adder-tree signals of conv_sum_scheduler.
// Handshake: a transfer happens on every rising edge where valid and ready are both 1;
// valid never depends on ready, and data holds while valid=1 and ready=0.
interface conv_sum_scheduler_if #(
    parameter int BITSIZE    = 14,
    parameter int NUM_INPUTS = 27,
    parameter int BIAS_SIZE  = 14
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_INPUTS*BITSIZE-1:0]   in_data;

    logic [7:0]                      bias_addr;
    logic [BIAS_SIZE-1:0]            bias_data;

    logic                            adder_start;
    logic [NUM_INPUTS*BITSIZE-1:0]   adder_data;
    logic [BIAS_SIZE-1:0]            adder_bias;
    logic                            adder_valid;
    logic [BITSIZE+4:0]              adder_sum;

    logic                            out_valid;
    logic                            out_ready;
    logic [BITSIZE+4:0]              out_data;
    logic                            out_last;

    modport slave (
        input  in_valid, in_data, bias_data, adder_valid, adder_sum, out_ready,
        output in_ready, bias_addr, adder_start, adder_data, adder_bias,
               out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, bias_data, adder_valid, adder_sum, out_ready,
        input  in_ready, bias_addr, adder_start, adder_data, adder_bias,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_sum_scheduler.sv
// Schedules window products into an external adder tree, adds per-channel bias,
// and buffers the fixed-latency sums in a credit-limited result FIFO.
module conv_sum_scheduler #(
    parameter int BITSIZE    = 14,
    parameter int NUM_INPUTS = 27,
    parameter int BIAS_SIZE  = 14,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [CNT_W-1:0]     cfg_num_windows,
    input  logic [7:0]           cfg_num_channels,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           dbg_state,
    conv_sum_scheduler_if.slave  io
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = BITSIZE + 5;
    localparam int TW = CNT_W + 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  nw_q;
    logic [7:0]        nc_q;
    logic [TW-1:0]     total_q;
    logic [CNT_W-1:0]  win_cnt;
    logic [7:0]        ch_cnt;
    logic [TW-1:0]     retire_cnt;
    logic              last_popped;
    logic [CW-1:0]     inflight;
    logic              err_q;

    logic [SW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    logic              start_ok;
    logic              cfg_zero;
    logic [CW:0]       occupancy;
    logic              room;
    logic              in_ready_c;
    logic              accept;
    logic              win_last;
    logic              ch_last;
    logic              last_accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              drop;
    logic              pop;
    logic              dec;
    logic              head_last;

    // ---------------------------------------------------------------------
    // Datapath conditions
    // ---------------------------------------------------------------------
    always_comb begin
        start_ok    = (state == S_IDLE) && cfg_start;
        cfg_zero    = (cfg_num_windows == '0) || (cfg_num_channels == '0);
        // Credit check: every accepted window will eventually need a FIFO slot.
        occupancy   = {1'b0, fifo_cnt} + {1'b0, inflight};
        room        = occupancy < (CW+1)'(FIFO_DEPTH);
        accept      = io.in_valid && in_ready_c;
        win_last    = win_cnt == (nw_q - CNT_W'(1));
        ch_last     = ch_cnt == (nc_q - 8'd1);
        last_accept = accept && win_last && ch_last;
        fifo_full   = fifo_cnt == CW'(FIFO_DEPTH);
        fifo_empty  = fifo_cnt == '0;
        push        = io.adder_valid && (state != S_IDLE) && !fifo_full;
        drop        = io.adder_valid && ((state == S_IDLE) || fifo_full);
        pop         = !fifo_empty && io.out_ready;
        dec         = io.adder_valid && (inflight != '0);
        head_last   = retire_cnt == (total_q - TW'(1));
    end

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = cfg_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_accept) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && fifo_empty && last_popped) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state == S_RUN) || (state == S_DRAIN);
        done       = (state == S_DONE);
        in_ready_c = (state == S_RUN) && room;
        dbg_state  = state;
    end

    // ---------------------------------------------------------------------
    // Job configuration, window/channel walk and retire tracking
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nw_q        <= '0;
            nc_q        <= '0;
            total_q     <= '0;
            win_cnt     <= '0;
            ch_cnt      <= '0;
            retire_cnt  <= '0;
            last_popped <= 1'b0;
        end else if (start_ok) begin
            nw_q        <= cfg_num_windows;
            nc_q        <= cfg_num_channels;
            total_q     <= TW'(cfg_num_windows) * TW'(cfg_num_channels);
            win_cnt     <= '0;
            ch_cnt      <= '0;
            retire_cnt  <= '0;
            last_popped <= 1'b0;
        end else begin
            if (accept) begin
                if (win_last) begin
                    win_cnt <= '0;
                    ch_cnt  <= ch_cnt + 8'd1;
                end else begin
                    win_cnt <= win_cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                retire_cnt <= retire_cnt + TW'(1);
                if (head_last) begin
                    last_popped <= 1'b1;
                end
            end
        end
    end

    // Sums still inside the adder tree; bounded by the credit check above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else if (start_ok) begin
            inflight <= '0;
        end else begin
            case ({accept, dec})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (drop) begin
            err_q <= 1'b1;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Result FIFO
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= io.adder_sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (start_ok) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output drive
    // ---------------------------------------------------------------------
    always_comb begin
        err            = err_q;
        io.in_ready    = in_ready_c;
        io.bias_addr   = ch_cnt;
        io.adder_start = accept;
        io.adder_data  = accept ? io.in_data : '0;
        io.adder_bias  = accept ? io.bias_data : '0;
        io.out_valid   = !fifo_empty;
        // Gate the head so an unwritten RAM entry never leaks out while empty.
        io.out_data    = fifo_empty ? '0 : mem[rd_ptr];
        io.out_last    = !fifo_empty && head_last;
    end
endmodule

// File: tb/tb_conv_sum_scheduler.sv
// Self-checking bench for conv_sum_scheduler: adder-tree responder, job-level
// reference model with expected-result queue, and directed plus random jobs.
module tb_conv_sum_scheduler;
    localparam int BITSIZE    = 14;
    localparam int NUM_INPUTS = 27;
    localparam int BIAS_SIZE  = 14;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 16;
    localparam int DW         = NUM_INPUTS * BITSIZE;
    localparam int SW         = BITSIZE + 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              cfg_start = 1'b0;
    logic [CNT_W-1:0]  cfg_nw    = '0;
    logic [7:0]        cfg_nc    = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        dbg_state;

    conv_sum_scheduler_if #(.BITSIZE(BITSIZE), .NUM_INPUTS(NUM_INPUTS), .BIAS_SIZE(BIAS_SIZE)) io ();

    conv_sum_scheduler #(
        .BITSIZE(BITSIZE), .NUM_INPUTS(NUM_INPUTS), .BIAS_SIZE(BIAS_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_num_windows(cfg_nw),
        .cfg_num_channels(cfg_nc),
        .busy(busy),
        .done(done),
        .err(err),
        .dbg_state(dbg_state),
        .io(io)
    );

    // ---------------- check bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [SW-1:0] model_sum(input logic [DW-1:0] d, input logic [BIAS_SIZE-1:0] b);
        int s;
        logic signed [BITSIZE-1:0]   p;
        logic signed [BIAS_SIZE-1:0] sb;
        sb = b;
        s  = sb;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            p = d[i*BITSIZE +: BITSIZE];
            s += p;
        end
        return SW'(s);
    endfunction

    // ---------------- environment: bias ROM and adder tree ----------------
    logic [BIAS_SIZE-1:0] bias_tab [256];
    assign io.bias_data = bias_tab[io.bias_addr];

    logic [4:0]    pv;
    logic [SW-1:0] ps [5];
    logic          stray_v = 1'b0;
    logic [SW-1:0] stray_d = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[3:0], io.adder_start};
            ps[0] <= model_sum(io.adder_data, io.adder_bias);
            for (int i = 1; i < 5; i++) ps[i] <= ps[i-1];
        end
    end
    assign io.adder_valid = pv[4] | stray_v;
    assign io.adder_sum   = stray_v ? stray_d : ps[4];

    // ---------------- reference model / scoreboard state ----------------
    logic [SW-1:0] exp_q [$];
    bit            last_q [$];
    logic [SW-1:0] got_log [$];
    logic [7:0]    ba_log [$];
    bit  m_active = 0;
    int  m_nw = 0, m_total = 0, m_acc = 0, m_pop = 0;
    int  cyc = 0, last_pop_cyc = 0, done_cyc = 0;
    int  as_cnt = 0, ov_cnt = 0;
    bit  last_acc = 0, stall_prev = 0;
    logic [SW-1:0] prev_d;
    logic          prev_l;

    // ---------------- driver ----------------
    int in_mode  = 0;   // 0 idle, 1 valid held, 2 random valid
    int or_mode  = 1;   // 0 never ready, 1 always ready, 2 random
    bit ones_data = 0;

    initial begin
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (in_mode == 0) begin
                io.in_valid = 1'b0;
            end else if (!(io.in_valid && !last_acc)) begin
                io.in_valid = (in_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                for (int i = 0; i < NUM_INPUTS; i++)
                    io.in_data[i*BITSIZE +: BITSIZE] = ones_data ? BITSIZE'(1) : BITSIZE'($urandom);
            end
            io.out_ready = (or_mode == 0) ? 1'b0 : (or_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- compare process ----------------
    bit            acc_now;
    bit            exp_rdy;
    int            ch;
    logic [SW-1:0] e;
    bit            l;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            last_acc   = 0;
            stall_prev = 0;
        end else begin
            acc_now = io.in_valid && io.in_ready;
            exp_rdy = m_active && (m_acc < m_total) && ((m_acc - m_pop) < FIFO_DEPTH);
            chk(io.in_ready == exp_rdy, "in_ready", io.in_ready, exp_rdy);
            if (m_active && (m_acc < m_total)) chk(busy, "busy_run", busy, 1);
            chk((io.adder_start == acc_now) && (acc_now || (io.adder_data == '0 && io.adder_bias == '0)),
                "adder_start", io.adder_start, acc_now);
            if (io.adder_start) as_cnt++;
            if (io.out_valid) ov_cnt++;
            if (acc_now && m_nw != 0) begin
                ch = m_acc / m_nw;
                chk(io.bias_addr == 8'(ch), "bias_addr", io.bias_addr, ch);
                chk(io.adder_data == io.in_data && io.adder_bias == bias_tab[ch],
                    "adder_operands", io.adder_bias, bias_tab[ch]);
                exp_q.push_back(model_sum(io.in_data, bias_tab[ch]));
                last_q.push_back(m_acc == m_total - 1);
                ba_log.push_back(io.bias_addr);
                m_acc++;
            end
            if (stall_prev)
                chk(io.out_valid && io.out_data == prev_d && io.out_last == prev_l,
                    "out_hold", io.out_data, prev_d);
            if (exp_q.size() == 0) chk(!io.out_valid, "no_spurious_out", io.out_valid, 0);
            if (io.out_valid && io.out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                l = last_q.pop_front();
                chk(io.out_data == e, "out_data", io.out_data, e);
                chk(io.out_last == l, "out_last", io.out_last, l);
                got_log.push_back(io.out_data);
                m_pop++;
                last_pop_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            stall_prev = io.out_valid && !io.out_ready;
            prev_d     = io.out_data;
            prev_l     = io.out_last;
            last_acc   = acc_now;
        end
    end

    // ---------------- tasks ----------------
    task automatic start_job(input int nw, input int nc);
        @(posedge clk);
        #1;
        cfg_nw    = CNT_W'(nw);
        cfg_nc    = 8'(nc);
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        exp_q.delete();
        last_q.delete();
        got_log.delete();
        ba_log.delete();
        m_nw     = nw;
        m_total  = nw * nc;
        m_acc    = 0;
        m_pop    = 0;
        as_cnt   = 0;
        ov_cnt   = 0;
        m_active = 1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            #1;
            if (done) seen = 1;
            n++;
        end
        chk(seen, "done_seen", n, budget);
        if (seen) begin
            @(negedge clk);
            #1;
            chk(!done, "done_one_cycle", done, 0);
        end
        chk(m_pop == m_total && exp_q.size() == 0, "all_results", m_pop, m_total);
        chk(!err, "err_clear", err, 0);
        m_active = 0;
    endtask

    task automatic check_outputs_zero(input string name);
        chk({io.in_ready, busy, done, err, io.adder_start, io.out_valid, io.out_last} == '0,
            name, {io.in_ready, busy, done, err, io.adder_start, io.out_valid, io.out_last}, 0);
        chk(io.adder_data == '0 && io.adder_bias == '0 && io.out_data == '0 && io.bias_addr == '0,
            {name, "_buses"}, io.out_data, 0);
    endtask

    // ---------------- test sequence ----------------
    logic [DW-1:0] ones_vec;
    int            gap;

    initial begin : main
        for (int i = 0; i < 256; i++) bias_tab[i] = BIAS_SIZE'($urandom);
        bias_tab[0] = 14'd5;
        bias_tab[1] = 14'h3FF9;   // -7
        for (int i = 0; i < NUM_INPUTS; i++) ones_vec[i*BITSIZE +: BITSIZE] = BITSIZE'(1);

        // Hand-computed pins of the reference sum
        chk(model_sum(ones_vec, 14'd5) == 19'd32, "model_pin_pos", model_sum(ones_vec, 14'd5), 32);
        chk(model_sum(ones_vec, 14'h3FF9) == 19'd20, "model_pin_neg", model_sum(ones_vec, 14'h3FF9), 20);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        @(posedge clk);
        #3;
        rst = 1'b1;

        // Directed job: 3 windows x 2 channels, constant products
        ones_data = 1;
        in_mode   = 1;
        or_mode   = 1;
        start_job(3, 2);
        wait_done(200);
        chk(as_cnt == 6, "t1_adder_starts", as_cnt, 6);
        chk(got_log.size() == 6, "t1_result_count", got_log.size(), 6);
        if (got_log.size() == 6) begin
            chk(got_log[0] == 19'd32 && got_log[1] == 19'd32 && got_log[2] == 19'd32,
                "t1_ch0_sums", got_log[0], 32);
            chk(got_log[3] == 19'd20 && got_log[4] == 19'd20 && got_log[5] == 19'd20,
                "t1_ch1_sums", got_log[3], 20);
        end
        chk(ba_log.size() == 6 && ba_log[0] == 0 && ba_log[2] == 0 && ba_log[3] == 1 && ba_log[5] == 1,
            "t1_bias_addr_seq", ba_log.size(), 6);
        gap = done_cyc - last_pop_cyc;
        chk(gap >= 1 && gap <= 2, "t1_done_after_pop", gap, 1);
        ones_data = 0;

        // Back-pressure: 20 windows with output stalled
        in_mode = 1;
        or_mode = 0;
        start_job(20, 1);
        repeat (40) @(posedge clk);
        #1;
        chk(m_acc == 8, "t2_accepts_stalled", m_acc, 8);
        chk(!io.in_ready, "t2_in_ready_low", io.in_ready, 0);
        or_mode = 1;
        wait_done(500);
        chk(m_acc == 20, "t2_accepts_total", m_acc, 20);

        // Empty jobs finish immediately with no traffic
        start_job(0, 4);
        wait_done(3);
        chk(as_cnt == 0 && ov_cnt == 0, "t3_no_traffic_w0", as_cnt, 0);
        start_job(5, 0);
        wait_done(3);
        chk(as_cnt == 0 && ov_cnt == 0, "t3_no_traffic_c0", as_cnt, 0);

        // Ignored cfg_start mid-job, then concurrent push/pop after a stall
        in_mode = 1;
        or_mode = 0;
        start_job(12, 1);
        repeat (4) @(posedge clk);
        #1;
        cfg_nw    = 16'd2;
        cfg_nc    = 8'd2;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        repeat (5) @(posedge clk);
        or_mode = 1;
        wait_done(300);

        // Reset mid-run with three sums in flight
        in_mode = 1;
        or_mode = 0;
        start_job(9, 3);
        gap = 0;
        while (m_acc < 3 && gap < 20) begin
            @(posedge clk);
            #1;
            gap++;
        end
        chk(m_acc == 3, "t5_three_inflight", m_acc, 3);
        #1;
        rst = 1'b0;
        #1;
        check_outputs_zero("t5_reset_outputs");
        m_active = 0;
        exp_q.delete();
        last_q.delete();
        in_mode = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            stray_v = 1'b1;
            stray_d = SW'($urandom);
        end
        @(posedge clk);
        #1;
        stray_v = 1'b0;
        @(negedge clk);
        #1;
        chk(err, "t5_err_set", err, 1);
        chk(!io.out_valid, "t5_fifo_empty", io.out_valid, 0);

        // Random valid and output throttling, 9 windows x 3 channels
        in_mode = 2;
        or_mode = 2;
        start_job(9, 3);
        wait_done(2000);
        chk(got_log.size() == 27, "t6_result_count", got_log.size(), 27);

        in_mode = 0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
